barrett_share_arbiter: RTL
==========================

// Module: barrett_share_arbiter
// PURPOSE
//  Shares one pipelined Barrett mod-Q reduction datapath (Q=1709) between N_REQ requesters.
//  Round-robin arbitration, valid/ready on both sides, result tagged with requester id.
//  Sits between NTT/poly-mult engines producing double-width products and their write-back.
//  Throughput 1 reduction/cycle when the output is not back-pressured.
// PARAMETERS
//  N_REQ  4     number of requesters (>=2)
//  Q      1709  modulus
//  K      11    bits of Q (2^(K-1) < Q < 2^K)
//  MU     2454  floor(2^(2K)/Q)
//  DW     21    input operand width (= 2K-1); operand a < 2^DW
//  IDW    2     $clog2(N_REQ)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   N_REQ     per-requester operand valid
//  req_data   in   N_REQ*DW  operands, requester i at [i*DW +: DW]
//  req_ready  out  N_REQ     one-hot (or zero) accept, combinational
//  res_valid  out  1         reduced result valid
//  res_data   out  K         a mod Q, in [0,Q)
//  res_id     out  IDW       index of requester that supplied the operand
//  res_ready  in   1         downstream accept
//  stat_stall_cnt out 32     present only with BARRETT_ARB_STATS_EN
// BEHAVIOUR
//  - One clock (clk); rst synchronous active-high. On rst: all stage valids 0, res_valid 0,
//    res_data 0, res_id 0, RR pointer 0 (requester 0 highest priority), stall counter 0.
//  - advance = !res_valid || res_ready. All pipeline stages shift together only when advance=1;
//    otherwise every stage holds (global stall, no bubble collapse).
//  - Arbitration: when advance, grant the first asserted req_valid at/after pointer, wrapping
//    N_REQ-1 -> 0. req_ready[i] = advance && grant[i]. Transfer = req_valid[i] && req_ready[i].
//  - After a transfer from i, pointer <= (i+1) mod N_REQ. No transfer -> pointer unchanged.
//  - req_ready never depends on res_valid/res_ready except through advance; requesters must
//    hold req_valid/req_data stable until accepted. req_valid with no grant is not dropped.
//  - Datapath, full-width intermediates (no truncation):
//      S1: qv = a >> K;  qh = qv * MU (DW+2 bits); register a, qh, id.
//      S2: t = qh >> K;  r = a - t*Q (r in [0,3Q)); register r, id.
//      S3: r>=2Q ? r-2Q : r>=Q ? r-Q : r -> res_data; id -> res_id.
//  - Latency: transfer in cycle n -> res_valid in cycle n+3 (absent stalls). Stall cycles add 1:1.
//  - res_valid && !res_ready: res_data/res_id held stable until accepted.
//  - Simultaneous output accept and new grant in one cycle: legal, full throughput.
//  - rst asserted mid-operation: in-flight operands discarded, no res_valid afterwards.
//  - All requesters idle: bubbles (valid=0) propagate; res_data holds last value.
// CONFIGURATION
//  BARRETT_ARB_STATS_EN defined: stat_stall_cnt counts cycles with res_valid && !res_ready,
//    saturates at 2^32-1, cleared by rst.
//  Not defined: port and counter removed; behaviour otherwise identical.
// STRUCTURE
//  barrett_pkg: Q, K, MU, DW constants, IDW derivation function, mod-Q result typedef.
//  Sub-module barrett_reduce_pipe: 3-stage datapath with enable, valid and IDW-bit tag side-band.
//  Top level: RR arbiter, pointer register, advance logic, optional stats counter.
// TESTING
//  1. Single requester 0, a=0,1708,1709,3417 back-to-back, res_ready=1 -> 0,1708,0,1708, id 0,
//     1 result/cycle, first at +3 cycles.
//  2. a=2097151 (2^21-1) -> 208; random a vs golden a%1709, 10k vectors, all requesters.
//  3. All 4 requesters valid continuously -> grants 0,1,2,3,0,...; res_id sequence matches.
//  4. res_ready low 5 cycles with full pipe -> req_ready all 0, res held, no loss/dup on release;
//     stat_stall_cnt +5 with BARRETT_ARB_STATS_EN.
//  5. Reqs 1,3 valid, pointer at 2 -> grant 3 then 1; idle 0,2 never granted.
//  6. rst asserted with 3 ops in flight -> res_valid 0 next cycle, pointer 0, nothing emitted.

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared constants and types for the Q=1709 Barrett reduction datapath and its arbiter.
package barrett_pkg;

  localparam int Q   = 1709;
  localparam int K   = 11;
  localparam int MU  = 2454;
  localparam int DW  = 2 * K - 1;
  localparam int QHW = DW + 2;
  localparam int TW  = QHW - K;
  localparam int TPW = TW + K;
  localparam int RW  = K + 2;

  typedef logic [K-1:0] modq_t;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett mod-Q reduction with a global enable, valid bit and id tag side-band.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int IDW = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           valid_i,
  input  logic [DW-1:0]  a_i,
  input  logic [IDW-1:0] id_i,
  output logic           valid_o,
  output modq_t          res_o,
  output logic [IDW-1:0] id_o
);

  localparam logic [QHW-1:0] MU_W = QHW'(MU);
  localparam logic [TPW-1:0] Q_W  = TPW'(Q);
  localparam logic [RW-1:0]  R1Q  = RW'(Q);
  localparam logic [RW-1:0]  R2Q  = RW'(2 * Q);

  logic           s1_v_q;
  logic [DW-1:0]  s1_a_q;
  logic [QHW-1:0] s1_qh_q, s1_qh_d;
  logic [IDW-1:0] s1_id_q;

  logic           s2_v_q;
  logic [RW-1:0]  s2_r_q, s2_r_d;
  logic [IDW-1:0] s2_id_q;

  logic           s3_v_q;
  modq_t          s3_res_q, s3_res_d;
  logic [IDW-1:0] s3_id_q;

  logic [TW-1:0]  t_w;
  logic [TPW-1:0] tq_w;

  always_comb begin
    s1_qh_d = QHW'(a_i >> K) * MU_W;
    t_w     = TW'(s1_qh_q >> K);
    tq_w    = TPW'(t_w) * Q_W;
    // Exact result is below 3Q < 2^RW, so modular RW-bit subtraction is lossless.
    s2_r_d  = RW'(s1_a_q) - RW'(tq_w);
    if (s2_r_q >= R2Q) begin
      s3_res_d = K'(s2_r_q - R2Q);
    end else if (s2_r_q >= R1Q) begin
      s3_res_d = K'(s2_r_q - R1Q);
    end else begin
      s3_res_d = K'(s2_r_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_qh_q  <= '0;
      s1_id_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_r_q   <= '0;
      s2_id_q  <= '0;
      s3_v_q   <= 1'b0;
      s3_res_q <= '0;
      s3_id_q  <= '0;
    end else if (en_i) begin
      s1_v_q <= valid_i;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
      if (valid_i) begin
        s1_a_q  <= a_i;
        s1_qh_q <= s1_qh_d;
        s1_id_q <= id_i;
      end
      if (s1_v_q) begin
        s2_r_q  <= s2_r_d;
        s2_id_q <= s1_id_q;
      end
      // Bubbles leave the output data at its last value.
      if (s2_v_q) begin
        s3_res_q <= s3_res_d;
        s3_id_q  <= s2_id_q;
      end
    end
  end

  assign valid_o = s3_v_q;
  assign res_o   = s3_res_q;
  assign id_o    = s3_id_q;

endmodule

// File: rtl/barrett_share_arbiter.sv
// Round-robin sharing of one Barrett mod-Q pipeline among N_REQ requesters.
// Optional stall statistics counter enabled by defining BARRETT_ARB_STATS_EN.
module barrett_share_arbiter
  import barrett_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = clog2_f(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                res_valid,
  output logic [K-1:0]        res_data,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready
`ifdef BARRETT_ARB_STATS_EN
  ,
  output logic [31:0]         stat_stall_cnt
`endif
);

  logic             advance;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   cidx;
  logic             found;
  logic             xfer;
  logic [DW-1:0]    sel_data;
  int               cand;

  assign advance = !res_valid || res_ready;

  always_comb begin
    grant = '0;
    gidx  = '0;
    cidx  = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = IDW'(cand);
      if (!found && req_valid[cidx]) begin
        grant[cidx] = 1'b1;
        gidx        = cidx;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_data = req_data[i*DW +: DW];
    end
  end

  assign req_ready = advance ? grant : '0;
  assign xfer      = advance && found;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gidx == IDW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  barrett_reduce_pipe #(
    .IDW(IDW)
  ) u_pipe (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (advance),
    .valid_i(xfer),
    .a_i    (sel_data),
    .id_i   (gidx),
    .valid_o(res_valid),
    .res_o  (res_data),
    .id_o   (res_id)
  );

`ifdef BARRETT_ARB_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (res_valid && !res_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stat_stall_cnt = stall_q;
`endif

endmodule
